// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and default parameter values for the FIFO-draining UART transmitter.
// State encodings are 3-bit so they match the legacy define-file values one for one.
package fifo_uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_LOAD   = 3'd2,
      ST_START  = 3'd3,
      ST_DATA   = 3'd4,
      ST_PARITY = 3'd5,
      ST_STOP   = 3'd6
   } state_e;

   localparam int unsigned DEF_CLKS_PER_BIT = 16;
   localparam int unsigned DEF_DATA_WIDTH   = 8;
   localparam int unsigned DEF_PARITY_EN    = 0;
   localparam int unsigned DEF_PARITY_ODD   = 0;
   localparam int unsigned DEF_STOP_BITS    = 1;

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the synchronous FIFO and the UART transmitter.
// master = transmitter (issues read strobes), slave = FIFO.
interface fifo_uart_tx_if
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_read_n;

   modport master (input fifo_empty, input fifo_data, output fifo_read_n);
   modport slave  (output fifo_empty, output fifo_data, input fifo_read_n);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick_o on the terminal count.
// clear_i holds the count at zero so the first bit after a clear is a full period.
module uart_baud_gen
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear_i,
   output logic tick_o
);
   localparam int unsigned      CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick_o = !clear_i && (cnt_q == TERMINAL);
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains the FIFO one byte at a time and sends each as a UART frame, LSB first.
// tx and the read strobe are registered from the next state so both are glitch-free.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int unsigned PARITY_EN    = DEF_PARITY_EN,
   parameter int unsigned PARITY_ODD   = DEF_PARITY_ODD,
   parameter int unsigned STOP_BITS    = DEF_STOP_BITS
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                tx_enable_i,
   fifo_uart_tx_if.master      fifo_if,
   output logic                tx_o,
   output logic                busy_o,
   output logic                frame_done_o,
   output logic [15:0]         frame_count_o
);
   localparam int unsigned      IDX_W     = $clog2(DATA_WIDTH + 1);
   localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  tx_q, tx_d;
   logic                  rd_n_q, rd_n_d;
   logic [15:0]           count_q, count_d;
   logic                  tick, baud_clear, stop_last, can_fetch;

   // Counter is parked outside the frame so START always begins at count 0.
   assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_FETCH) || (state_q == ST_LOAD);

   uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clock   (clock),
      .reset_n (reset_n),
      .clear_i (baud_clear),
      .tick_o  (tick)
   );

   // fifo_empty is only trusted in IDLE and on the last stop cycle; it lags the read edge.
   assign can_fetch = tx_enable_i && !fifo_if.fifo_empty;
   assign stop_last = (state_q == ST_STOP) && tick && (idx_q == LAST_STOP);

   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      idx_d    = idx_q;
      count_d  = count_q;
      unique case (state_q)
         ST_IDLE:  if (can_fetch) state_d = ST_FETCH;
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            shift_d  = fifo_if.fifo_data;
            parity_d = (PARITY_ODD != 0);
            idx_d    = '0;
            state_d  = ST_START;
         end
         ST_START: if (tick) begin
            idx_d   = '0;
            state_d = ST_DATA;
         end
         ST_DATA: if (tick) begin
            parity_d = parity_q ^ shift_q[0];
            if (idx_q == LAST_DATA) begin
               idx_d   = '0;
               state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
               idx_d   = idx_q + 1'b1;
               shift_d = shift_q >> 1;
            end
         end
         ST_PARITY: if (tick) begin
            idx_d   = '0;
            state_d = ST_STOP;
         end
         ST_STOP: if (tick) begin
            if (idx_q == LAST_STOP) begin
               count_d = count_q + 16'd1;
               state_d = can_fetch ? ST_FETCH : ST_IDLE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      unique case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = parity_d;
         default:   tx_d = 1'b1;
      endcase
      rd_n_d = (state_d != ST_FETCH);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         shift_q  <= '0;
         parity_q <= 1'b0;
         idx_q    <= '0;
         tx_q     <= 1'b1;
         rd_n_q   <= 1'b1;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         parity_q <= parity_d;
         idx_q    <= idx_d;
         tx_q     <= tx_d;
         rd_n_q   <= rd_n_d;
         count_q  <= count_d;
      end
   end

   assign fifo_if.fifo_read_n = rd_n_q;
   assign tx_o                = tx_q;
   assign busy_o              = (state_q != ST_IDLE);
   assign frame_done_o        = stop_last;
   assign frame_count_o       = count_q;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: 8N1, 8E2 and 8O2 transmitters at 4 clocks per bit, each fed by a small FIFO model.
module tb_fifo_uart_tx;
   localparam int CPB = 4;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic en0 = 1'b1, en1 = 1'b1, en2 = 1'b1;
   always #5 clock = ~clock;

   fifo_uart_tx_if #(.DATA_WIDTH(8)) if0 ();
   fifo_uart_tx_if #(.DATA_WIDTH(8)) if1 ();
   fifo_uart_tx_if #(.DATA_WIDTH(8)) if2 ();

   logic        tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2;
   logic [15:0] cnt0, cnt1, cnt2;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
      .clock(clock), .reset_n(reset_n), .tx_enable_i(en0), .fifo_if(if0.master),
      .tx_o(tx0), .busy_o(busy0), .frame_done_o(done0), .frame_count_o(cnt0));
   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
      .clock(clock), .reset_n(reset_n), .tx_enable_i(en1), .fifo_if(if1.master),
      .tx_o(tx1), .busy_o(busy1), .frame_done_o(done1), .frame_count_o(cnt1));
   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
      .clock(clock), .reset_n(reset_n), .tx_enable_i(en2), .fifo_if(if2.master),
      .tx_o(tx2), .busy_o(busy2), .frame_done_o(done2), .frame_count_o(cnt2));

   // FIFO models: registered data and empty flag, both updated on the read edge.
   logic [7:0] fq0[$], fq1[$], fq2[$];
   logic       e0 = 1'b1, e1 = 1'b1, e2 = 1'b1;
   logic [7:0] d0 = 8'h00, d1 = 8'h00, d2 = 8'h00;
   assign if0.fifo_empty = e0;
   assign if0.fifo_data  = d0;
   assign if1.fifo_empty = e1;
   assign if1.fifo_data  = d1;
   assign if2.fifo_empty = e2;
   assign if2.fifo_data  = d2;

   always @(posedge clock) begin
      if (!if0.fifo_read_n && fq0.size() != 0) d0 <= fq0.pop_front();
      e0 <= (fq0.size() == 0);
      if (!if1.fifo_read_n && fq1.size() != 0) d1 <= fq1.pop_front();
      e1 <= (fq1.size() == 0);
      if (!if2.fifo_read_n && fq2.size() != 0) d2 <= fq2.pop_front();
      e2 <= (fq2.size() == 0);
   end

   int cyc = 0;
   int rd0 = 0;
   int rdt0[$];
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (!if0.fifo_read_n) begin
         rd0 = rd0 + 1;
         rdt0.push_back(cyc);
      end
   end

   int   sel = 0;
   logic tx_m, done_m;
   always_comb begin
      tx_m   = tx0;
      done_m = done0;
      case (sel)
         1: begin tx_m = tx1; done_m = done1; end
         2: begin tx_m = tx2; done_m = done2; end
         default: begin tx_m = tx0; done_m = done0; end
      endcase
   end

   int tests = 0;
   int fails = 0;

   function automatic logic exp_bit(input logic [7:0] b, input int k, input int pe, input logic par);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && pe != 0) return par;
      return 1'b1;
   endfunction

   task automatic wait_tx_low(input string name, input int limit, output int n);
      n = 0;
      while (tx_m !== 1'b0 && n < limit) begin
         @(negedge clock);
         n++;
      end
      tests++;
      if (tx_m !== 1'b0) begin
         fails++;
         $display("FAIL %s start bit timeout: tx=%b after %0d cycles, required 0", name, tx_m, n);
      end
   endtask

   // Entered on the first start-bit cycle; leaves on the cycle after the last stop cycle.
   task automatic check_frame(input string name, input logic [7:0] b, input int pe, input logic par,
                              input int stops, input int drop_at);
      int   len;
      int   bad_at;
      logic bad_got, bad_exp, e;
      int   done_bad;
      len = (9 + pe + stops) * CPB;
      bad_at = -1;
      bad_got = 1'b0;
      bad_exp = 1'b0;
      done_bad = -1;
      for (int i = 0; i < len; i++) begin
         if (i == drop_at) en0 = 1'b0;
         e = exp_bit(b, i / CPB, pe, par);
         if (tx_m !== e && bad_at < 0) begin
            bad_at = i; bad_got = tx_m; bad_exp = e;
         end
         if (done_m !== (i == len - 1) && done_bad < 0) done_bad = i;
         @(negedge clock);
      end
      tests++;
      if (bad_at >= 0) begin
         fails++;
         $display("FAIL %s tx at frame cycle %0d: got %b, required %b", name, bad_at, bad_got, bad_exp);
      end
      tests++;
      if (done_bad >= 0) begin
         fails++;
         $display("FAIL %s frame_done wrong at frame cycle %0d (frame length %0d)", name, done_bad, len);
      end
   endtask

   task automatic test_reset();
      int bad;
      repeat (2) @(negedge clock);
      tests++;
      if (tx0 !== 1'b1 || if0.fifo_read_n !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0) begin
         fails++;
         $display("FAIL reset_outputs: tx=%b read_n=%b busy=%b done=%b, required 1 1 0 0",
                  tx0, if0.fifo_read_n, busy0, done0);
      end
      tests++;
      if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || cnt2 !== 16'd0) begin
         fails++;
         $display("FAIL reset_count: got %0d/%0d/%0d, required 0", cnt0, cnt1, cnt2);
      end
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (tx0 !== 1'b1 || if0.fifo_read_n !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 16'd0 ||
             tx1 !== 1'b1 || if1.fifo_read_n !== 1'b1 || busy1 !== 1'b0 ||
             tx2 !== 1'b1 || if2.fifo_read_n !== 1'b1 || busy2 !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL idle_hold: %0d of 100 empty cycles not idle, required 0", bad);
      end
   endtask

   task automatic test_single();
      int start, n;
      sel = 0;
      start = rd0;
      fq0.push_back(8'hA5);
      n = 0;
      while (if0.fifo_empty !== 1'b0 && n < 10) begin
         @(negedge clock);
         n++;
      end
      wait_tx_low("single", 20, n);
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL single_latency: got %0d cycles, required 3", n);
      end
      check_frame("single_A5", 8'hA5, 0, 1'b0, 1, -1);
      repeat (3) @(negedge clock);
      tests++;
      if (rd0 - start != 1 || cnt0 !== 16'd1 || busy0 !== 1'b0) begin
         fails++;
         $display("FAIL single_after: reads=%0d count=%0d busy=%b, required 1 1 0", rd0 - start, cnt0, busy0);
      end
   endtask

   task automatic test_back_to_back();
      int start, t0, n;
      logic [7:0] bytes [3];
      bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
      sel = 0;
      start = rd0;
      t0 = rdt0.size();
      for (int i = 0; i < 3; i++) fq0.push_back(bytes[i]);
      wait_tx_low("b2b0", 20, n);
      check_frame("b2b_00", bytes[0], 0, 1'b0, 1, -1);
      for (int f = 1; f < 3; f++) begin
         wait_tx_low("b2b", 20, n);
         tests++;
         if (n != 2) begin
            fails++;
            $display("FAIL b2b_gap frame %0d: idle-high %0d cycles, required 2", f, n);
         end
         check_frame("b2b_frame", bytes[f], 0, 1'b0, 1, -1);
      end
      repeat (3) @(negedge clock);
      tests++;
      if (rd0 - start != 3 || cnt0 !== 16'd4) begin
         fails++;
         $display("FAIL b2b_totals: reads=%0d count=%0d, required 3 4", rd0 - start, cnt0);
      end
      tests++;
      if (rdt0.size() < t0 + 3 || rdt0[t0+1] - rdt0[t0] != 42 || rdt0[t0+2] - rdt0[t0+1] != 42) begin
         fails++;
         $display("FAIL b2b_spacing: %0d read pulses recorded, spacing required 42", rdt0.size() - t0);
      end
   endtask

   task automatic test_parity();
      int n;
      sel = 1;
      fq1.push_back(8'h07);
      wait_tx_low("par_even", 20, n);
      check_frame("par_even", 8'h07, 1, 1'b1, 2, -1);
      sel = 2;
      fq2.push_back(8'h07);
      wait_tx_low("par_odd", 20, n);
      check_frame("par_odd", 8'h07, 1, 1'b0, 2, -1);
      @(negedge clock);
      tests++;
      if (cnt1 !== 16'd1 || cnt2 !== 16'd1 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
         fails++;
         $display("FAIL par_after: counts=%0d/%0d busy=%b/%b, required 1/1 0/0", cnt1, cnt2, busy1, busy2);
      end
   endtask

   task automatic test_enable_drop();
      int start, n;
      sel = 0;
      start = rd0;
      fq0.push_back(8'h11); fq0.push_back(8'h22); fq0.push_back(8'h33);
      wait_tx_low("drop", 20, n);
      check_frame("drop_11", 8'h11, 0, 1'b0, 1, 3 * CPB);
      repeat (20) @(negedge clock);
      tests++;
      if (rd0 - start != 1 || busy0 !== 1'b0 || tx0 !== 1'b1) begin
         fails++;
         $display("FAIL drop_halt: reads=%0d busy=%b tx=%b, required 1 0 1", rd0 - start, busy0, tx0);
      end
      en0 = 1'b1;
      @(negedge clock);
      tests++;
      if (if0.fifo_read_n !== 1'b0) begin
         fails++;
         $display("FAIL drop_resume: read_n=%b one cycle after enable, required 0", if0.fifo_read_n);
      end
      wait_tx_low("resume", 20, n);
      check_frame("resume_22", 8'h22, 0, 1'b0, 1, -1);
      wait_tx_low("resume", 20, n);
      check_frame("resume_33", 8'h33, 0, 1'b0, 1, -1);
      repeat (3) @(negedge clock);
      tests++;
      if (cnt0 !== 16'd7 || rd0 - start != 3) begin
         fails++;
         $display("FAIL drop_totals: count=%0d reads=%0d, required 7 3", cnt0, rd0 - start);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      sel = 0;
      fq0.push_back(8'h5A); fq0.push_back(8'hC3);
      wait_tx_low("rstmid", 20, n);
      repeat (10) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      tests++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || cnt0 !== 16'd0) begin
         fails++;
         $display("FAIL rstmid_async: tx=%b busy=%b count=%0d, required 1 0 0", tx0, busy0, cnt0);
      end
      @(negedge clock);
      reset_n = 1'b1;
      wait_tx_low("rstmid_refetch", 20, n);
      tests++;
      if (n != 3) begin
         fails++;
         $display("FAIL rstmid_latency: got %0d cycles, required 3", n);
      end
      check_frame("rstmid_C3", 8'hC3, 0, 1'b0, 1, -1);
      @(negedge clock);
      tests++;
      if (cnt0 !== 16'd1) begin
         fails++;
         $display("FAIL rstmid_count: got %0d, required 1", cnt0);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_parity();
      test_enable_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within 200000 time units");
      $fatal(1);
   end
endmodule
